// File: rtl/logic_result_checker.sv
// ---------------------------------------------------------------------------
// logic_result_checker
//
// Response-side checker for the bitwise/logical AND operator pair. Accepts
// one operand pair over a valid/ready handshake, waits LAT cycles, samples
// the DUT's bitwise (bt_in) and logical (lg_in) results and compares them
// against internally computed expectations. Keeps saturating pass/fail
// counters and a sticky error flag.
//
// Parameters:
//   WIDTH - operand / bitwise-result width
//   LAT   - acceptance-to-sample latency in cycles (1..15)
//   CNT_W - pass/fail counter width
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, stop           - one-cycle control pulses
//   in_valid, in_ready_o  - operand handshake
//   a, b                  - operands as applied to the DUT
//   bt_in, lg_in          - DUT bitwise AND / logical AND results
//   pass_cnt_o, fail_cnt_o, err_o - result tallies and sticky error
//   busy_o, done_o        - transaction in flight / halted after stop
//   fail_a_o, fail_b_o, fail_bt_o, fail_lg_o - first-failure trace
//
// Optional feature: define LOGIC_CHK_TRACE_EN to capture the first failing
// transaction on the fail_*_o ports; otherwise those ports are tied to 0.
// ---------------------------------------------------------------------------
module logic_result_checker #(
  parameter int WIDTH = 2,
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] bt_in,
  input  logic             lg_in,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] fail_a_o,
  output logic [WIDTH-1:0] fail_b_o,
  output logic [WIDTH-1:0] fail_bt_o,
  output logic             fail_lg_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0] exp_bt_q, exp_bt_d;
  logic             exp_lg_q, exp_lg_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic             stop_pend_q, stop_pend_d;

  logic handshake;
  logic start_clear;
  logic result_ok;

  assign handshake   = in_valid && (state_q == S_ARMED);
  // start is honoured only while not running a transaction.
  assign start_clear = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign result_ok   = (bt_in == exp_bt_q) && (lg_in == exp_lg_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      exp_bt_q    <= '0;
      exp_lg_q    <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of every other flop, independent of statement order.
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      exp_bt_q    <= exp_bt_d;
      exp_lg_q    <= exp_lg_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    // NOTE: every signal assigned in this block gets a hold default first,
    // so no path through the case statement can infer a latch.
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    exp_bt_d    = exp_bt_q;
    exp_lg_d    = exp_lg_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_ARMED;
          pass_cnt_d  = '0;
          fail_cnt_d  = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (handshake) begin
          exp_bt_d  = a & b;
          exp_lg_d  = (a != '0) && (b != '0);
          lat_cnt_d = LAT_LOAD;
          state_d   = S_WAIT;
          // stop coinciding with acceptance lets this transaction finish.
          if (stop) stop_pend_d = 1'b1;
        end else if (stop) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (stop) stop_pend_d = 1'b1;
        if (lat_cnt_q == 4'd0) state_d = S_CHECK;
        else                   lat_cnt_d = lat_cnt_q - 4'd1;
      end
      S_CHECK: begin
        if (result_ok) begin
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
        end else begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
          err_d = 1'b1;
        end
        if (stop_pend_q || stop) begin
          state_d     = S_DONE;
          stop_pend_d = 1'b0;
        end else begin
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o = (state_q == S_ARMED);
    busy_o     = (state_q == S_WAIT) || (state_q == S_CHECK);
    done_o     = (state_q == S_DONE);
    pass_cnt_o = pass_cnt_q;
    fail_cnt_o = fail_cnt_q;
    err_o      = err_q;
  end

`ifdef LOGIC_CHK_TRACE_EN
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH-1:0] tr_a_q, tr_b_q, tr_bt_q;
  logic             tr_lg_q;
  logic             first_fail;

  // Load only on the 0->1 transition of err.
  assign first_fail = (state_q == S_CHECK) && !result_ok && !err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      tr_a_q  <= '0;
      tr_b_q  <= '0;
      tr_bt_q <= '0;
      tr_lg_q <= 1'b0;
    end else begin
      if (handshake) begin
        op_a_q <= a;
        op_b_q <= b;
      end
      if (start_clear) begin
        tr_a_q  <= '0;
        tr_b_q  <= '0;
        tr_bt_q <= '0;
        tr_lg_q <= 1'b0;
      end else if (first_fail) begin
        tr_a_q  <= op_a_q;
        tr_b_q  <= op_b_q;
        tr_bt_q <= bt_in;
        tr_lg_q <= lg_in;
      end
    end
  end

  assign fail_a_o  = tr_a_q;
  assign fail_b_o  = tr_b_q;
  assign fail_bt_o = tr_bt_q;
  assign fail_lg_o = tr_lg_q;
`else
  assign fail_a_o  = '0;
  assign fail_b_o  = '0;
  assign fail_bt_o = '0;
  assign fail_lg_o = 1'b0;
`endif

endmodule

// File: doc/logic_result_checker.md
Name: logic_result_checker

Overview:
- Response-side counterpart to the bitwise/logical operator stimulus.
- Accepts one operand pair at a time over a valid/ready handshake, waits a fixed DUT latency, then samples the DUT's bitwise and logical results.
- Compares the sampled results against internally computed expected values and keeps saturating pass/fail tallies plus a sticky error flag.
- Sits beside the bitwise and logical operator instances in a self-checking harness or on-chip BIST.

Parameters:
- WIDTH, 2: operand and bitwise-result width in bits.
- LAT, 1: cycles from operand acceptance to DUT result sampling; legal range 1..15.
- CNT_W, 8: width of the pass and fail counters.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; arms the checker and clears counters and err_o.
- stop  input  1  one-cycle pulse; finishes the current transaction, then halts.
- in_valid  input  1  operand pair a/b is valid.
- in_ready_o  output  1  checker can accept an operand pair.
- a  input  WIDTH  operand A, as applied to the DUT.
- b  input  WIDTH  operand B, as applied to the DUT.
- bt_in  input  WIDTH  DUT bitwise AND result.
- lg_in  input  1  DUT logical AND result.
- pass_cnt_o  output  CNT_W  number of matching transactions, saturating.
- fail_cnt_o  output  CNT_W  number of mismatching transactions, saturating.
- err_o  output  1  sticky; set by any mismatch.
- busy_o  output  1  a transaction is in flight (WAIT or CHECK).
- done_o  output  1  halted after stop.

Behaviour:
- Reset: asynchronous, active-low, forces state IDLE; all outputs 0. Reset asserted mid-transaction aborts it silently, and no count is updated.
- States: IDLE, ARMED, WAIT, CHECK, DONE.
- IDLE: in_ready_o=0. start -> ARMED; on the same edge, pass_cnt_o, fail_cnt_o and err_o clear to 0.
- ARMED: in_ready_o=1. A handshake (in_valid && in_ready_o) captures a and b and computes:
  - exp_bt = a & b
  - exp_lg = (a != 0) && (b != 0)
  - then loads latency counter with LAT-1 and goes to WAIT.
- ARMED + stop with no handshake: -> DONE. If stop and a handshake occur on the same edge, the transaction is accepted and stop is latched as pending.
- WAIT: in_ready_o=0, busy_o=1. Counter decrements each cycle. Exit to CHECK on the cycle the counter reads 0; with LAT=1, WAIT lasts exactly one cycle.
- CHECK: busy_o=1 for one cycle; samples bt_in and lg_in in this cycle.
  - Match (bt_in==exp_bt and lg_in==exp_lg): pass_cnt_o increments.
  - Mismatch: fail_cnt_o increments and err_o sets.
  - Next state: DONE if stop is pending or stop is asserted now; otherwise ARMED.
- Total latency: acceptance edge to count update is LAT+1 clocks. Maximum throughput is one transaction per LAT+2 cycles.
- stop during WAIT or CHECK is latched as pending and never aborts the transaction.
- DONE: done_o=1; counters and err_o hold. start -> ARMED and clears counters, err_o and pending stop.
- start while ARMED, WAIT or CHECK is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap. err_o stays set even when fail_cnt_o is saturated.
- Operand comparison is unsigned; a or b equal to zero gives exp_lg=0 regardless of the other operand.

Optional Feature:
- Macro: LOGIC_CHK_TRACE_EN.
- With the macro defined, four extra outputs capture the first failing transaction since the last start or reset:
  - fail_a_o (WIDTH): operand A.
  - fail_b_o (WIDTH): operand B.
  - fail_bt_o (WIDTH): sampled bitwise result.
  - fail_lg_o (1): sampled logical result.
- These outputs are loaded only when err_o transitions 0->1, hold thereafter, and clear on start or reset.
- Without the macro, the same ports exist, are tied to 0, and no trace registers are synthesized.

Test Plan:
- Reset then start; apply four vectors with a correct DUT:
  - (a=00,b=01) -> bt 00, lg 0
  - (11,01) -> 01, 1
  - (00,11) -> 00, 0
  - (11,10) -> 10, 1
  - Required: pass_cnt_o=4, fail_cnt_o=0, err_o=0.
- Fault injection: apply (11,10) with lg_in forced to 0 -> fail_cnt_o=1 and err_o=1, both LAT+1 clocks after acceptance. With LOGIC_CHK_TRACE_EN: fail_a_o=11, fail_b_o=10, fail_bt_o=10, fail_lg_o=0.
- LAT=3, in_valid held high -> in_ready_o high for 1 cycle in every 5; busy_o high for 4 cycles per transaction.
- stop asserted during WAIT -> the transaction still completes and counts; then done_o=1 and in_ready_o=0. A following start clears counters to 0 and sets in_ready_o=1.
- CNT_W=2, six matching vectors -> pass_cnt_o saturates and holds at 3.
- rst_n pulled low during WAIT -> all outputs 0 immediately, without waiting for a clock edge. After release, the state is IDLE and in_ready_o stays 0 until start.
